// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin message arbiter that shares one uart_tx transmitter between
//   N_REQ byte producers. Ownership is granted per message (terminated by
//   req_last), so bytes of different requesters never interleave on the line.
//   Each byte is paced against the transmitter with a LOAD -> HOLD -> DRAIN
//   sequence: start pulse, one blind cycle while uart_tx drops ready, then
//   wait for ready to return.
//
// Parameters
//   N_REQ          number of requesters (2..8)
//   TIMEOUT_CYCLES stall limit while granted (only with UART_ARB_TIMEOUT_EN)
//
// Ports
//   clk         clock
//   rst         synchronous active-high reset
//   req_valid   per requester: byte presented
//   req_data    per requester byte, requester i at [8i+7:8i]
//   req_last    per requester: presented byte ends the message
//   req_ready   per requester: one-cycle accept pulse
//   tx_data     byte to uart_tx
//   tx_valid    one-cycle start pulse to uart_tx
//   tx_ready    uart_tx idle
//   grant       one-hot current message owner, zero when idle
//   busy        a grant is held
//   timeout_err one-cycle pulse when a grant is revoked by the stall timeout
//
// Build option
//   UART_ARB_TIMEOUT_EN: when defined, a granted requester that withholds
//   req_valid in LOAD for TIMEOUT_CYCLES cycles loses its grant. When not
//   defined, LOAD waits indefinitely and timeout_err is constant 0.

module uart_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic [N_REQ-1:0]   grant,
    output logic               busy,
    output logic               timeout_err
);

    localparam int IDX_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("uart_tx_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_DRAIN
    } state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   gidx_q;
    logic [N_REQ-1:0]   grant_q;
    logic [N_REQ-1:0]   req_ready_q;
    logic [7:0]         tx_data_q;
    logic               tx_valid_q;
    logic               busy_q;
    logic               last_q;

    logic               pick_found_d;
    logic [IDX_W-1:0]   pick_idx_d;
    logic [IDX_W-1:0]   next_ptr_d;
    logic               g_valid;
    logic               g_last;
    logic [7:0]         g_data;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]   stall_cnt_q;
    logic               timeout_err_q;
`endif

    // (base + off) mod N_REQ for base < N_REQ and off < N_REQ.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input int               off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N_REQ) begin
            sum = sum - N_REQ;
        end
        return IDX_W'(sum);
    endfunction

    // Round-robin search starting at ptr. Iterating from the far end lets
    // the nearest set request overwrite the others.
    always_comb begin
        pick_found_d = 1'b0;
        pick_idx_d   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid[wrap_add(ptr_q, k)]) begin
                pick_found_d = 1'b1;
                pick_idx_d   = wrap_add(ptr_q, k);
            end
        end
    end

    assign next_ptr_d = wrap_add(gidx_q, 1);

    // Select the granted requester's inputs; non-granted inputs are ignored.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                g_valid = req_valid[i];
                g_last  = req_last[i];
                g_data  = req_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            gidx_q      <= '0;
            grant_q     <= '0;
            req_ready_q <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            last_q      <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            stall_cnt_q   <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            // Strobes default low so each one lasts exactly one cycle.
            tx_valid_q  <= 1'b0;
            req_ready_q <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            timeout_err_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (pick_found_d) begin
                        grant_q <= N_REQ'(1) << pick_idx_d;
                        gidx_q  <= pick_idx_d;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
`ifdef UART_ARB_TIMEOUT_EN
                        stall_cnt_q <= '0;
`endif
                    end
                end
                S_LOAD: begin
                    if (g_valid && tx_ready) begin
                        tx_data_q   <= g_data;
                        tx_valid_q  <= 1'b1;
                        req_ready_q <= grant_q;
                        last_q      <= g_last;
                        state_q     <= S_HOLD;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    // Only cycles where the owner withholds data count;
                    // waiting on the transmitter is not the owner's fault.
                    else if (!g_valid) begin
                        if (stall_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                            timeout_err_q <= 1'b1;
                            grant_q       <= '0;
                            busy_q        <= 1'b0;
                            ptr_q         <= next_ptr_d;
                            state_q       <= S_IDLE;
                        end else begin
                            stall_cnt_q <= stall_cnt_q + 1'b1;
                        end
                    end
`endif
                end
                S_HOLD: begin
                    // uart_tx needs this cycle to deassert ready after the
                    // start pulse; sampling it now would see a stale idle.
                    state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (tx_ready) begin
                        if (last_q) begin
                            grant_q <= '0;
                            busy_q  <= 1'b0;
                            ptr_q   <= next_ptr_d;
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_LOAD;
`ifdef UART_ARB_TIMEOUT_EN
                            stall_cnt_q <= '0;
`endif
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign grant     = grant_q;
    assign busy      = busy_q;

`ifdef UART_ARB_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int N        = 4;
    localparam int TO       = 16;
    localparam int UART_GAP = 10;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_ready;
    logic [N-1:0]   grant;
    logic           busy;
    logic           timeout_err;

    int   uart_cnt = 0;
    logic stall    = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    // Stimulus per requester ({last, data}), expected bytes per requester,
    // and the expected order of message owners on the serial line.
    logic [8:0] rq   [N][$];
    logic [8:0] expb [N][$];
    int         own_q[$];

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .grant      (grant),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // UART model: busy for UART_GAP cycles after each start pulse.
    always @(posedge clk) begin
        if (tx_valid) uart_cnt <= UART_GAP;
        else if (uart_cnt != 0) uart_cnt <= uart_cnt - 1;
    end
    assign tx_ready = (uart_cnt == 0) && !stall;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic send(input int r, input logic [7:0] d, input logic l);
        rq[r].push_back({l, d});
        expb[r].push_back({l, d});
    endtask

    function automatic int exp_left();
        int s = 0;
        for (int i = 0; i < N; i++) s += expb[i].size() + rq[i].size();
        return s + own_q.size();
    endfunction

    task automatic flush();
        for (int i = 0; i < N; i++) begin
            rq[i].delete();
            expb[i].delete();
        end
        own_q.delete();
    endtask

    task automatic check_reset_outputs();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        flush();
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
    endtask

    task automatic wait_txv(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_valid && n < 300);
        if (!tx_valid) chk({tag, "_timeout"}, 32'(tx_valid), 1);
    endtask

    // From the HOLD cycle of a byte, step to the cycle where tx_ready returns.
    task automatic wait_drain_done(input string tag);
        int n = 0;
        @(negedge clk);
        while (!tx_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drain"}, 32'(tx_ready), 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || exp_left() != 0) && n < 3000);
        chk({tag, "_idle_busy"}, 32'(busy), 0);
        chk({tag, "_idle_sb"}, 32'(exp_left()), 0);
    endtask

    // Requester driver: present the front of each queue, advance on req_ready.
    initial begin
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    if (rq[i].size() != 0) void'(rq[i].pop_front());
                    req_valid[i] = 1'b0;
                end
                if (rq[i].size() == 0) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i]) begin
                    req_valid[i]        = 1'b1;
                    req_data[8*i +: 8]  = rq[i][0][7:0];
                    req_last[i]         = rq[i][0][8];
                end
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        logic       prev_txv;
        logic [8:0] e;
        int         o;
        prev_txv = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_txv = 1'b0;
            end else begin
                chk("ready_vs_txv", 32'(|req_ready), 32'(tx_valid));
                if (tx_valid) begin
                    chk("txv_gap", 32'(prev_txv), 0);
                    if (own_q.size() == 0) begin
                        chk("tx_unexpected", 32'(own_q.size()), 1);
                    end else begin
                        o = own_q[0];
                        chk("tx_grant", 32'(grant), 32'(1) << o);
                        chk("tx_req_ready", 32'(req_ready), 32'(1) << o);
                        if (expb[o].size() == 0) begin
                            chk("tx_extra", 32'(expb[o].size()), 1);
                        end else begin
                            e = expb[o].pop_front();
                            chk("tx_data", 32'(tx_data), 32'(e[7:0]));
                            if (e[8]) void'(own_q.pop_front());
                        end
                    end
                end
                prev_txv = tx_valid;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1;
        do_reset();

        // Single message from req0.
        send(0, 8'h41, 1'b0); send(0, 8'h42, 1'b0); send(0, 8'h0A, 1'b1);
        own_q.push_back(0);
        wait_txv("t1_b0");
        chk("t1_grant_b0", 32'(grant), 32'h1);
        wait_txv("t1_b1");
        wait_txv("t1_b2");
        wait_drain_done("t1");
        chk("t1_grant_held", 32'(grant), 32'h1);
        @(negedge clk);
        chk("t1_release_grant", 32'(grant), 0);
        chk("t1_release_busy", 32'(busy), 0);
        wait_idle("t1");

        // Tie after reset: req0 before req2, then repeated tie with ptr=3.
        do_reset();
        send(0, 8'h61, 1'b0); send(0, 8'h62, 1'b1);
        send(2, 8'h71, 1'b0); send(2, 8'h72, 1'b1);
        own_q.push_back(0); own_q.push_back(2);
        wait_idle("t2a");
        send(0, 8'h63, 1'b1); send(2, 8'h73, 1'b1);
        own_q.push_back(0); own_q.push_back(2);
        wait_txv("t2b_first");
        chk("t2b_first_grant", 32'(grant), 32'h1);
        wait_idle("t2b");

        // No interleave: req1 arrives during req0's second byte.
        send(0, 8'h31, 1'b0); send(0, 8'h32, 1'b0); send(0, 8'h33, 1'b1);
        own_q.push_back(0);
        wait_txv("t3_b0");
        wait_txv("t3_b1");
        send(1, 8'h51, 1'b0); send(1, 8'h52, 1'b1);
        own_q.push_back(1);
        wait_txv("t3_b2");
        chk("t3_last_owner", 32'(grant), 32'h1);
        wait_drain_done("t3");
        @(negedge clk);
        chk("t3_release", 32'(grant), 0);
        @(negedge clk);
        chk("t3_req1_grant", 32'(grant), 32'h2);
        wait_idle("t3");

        // Backpressure while req3 is granted.
        stall = 1'b1;
        send(3, 8'h77, 1'b1);
        own_q.push_back(3);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant != 4'b1000 && n < 50);
        chk("t4_grant", 32'(grant), 32'h8);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            chk("t4_stall_txv", 32'(tx_valid), 0);
            chk("t4_stall_rdy", 32'(req_ready), 0);
        end
        stall = 1'b0;
        @(negedge clk);
        chk("t4_resume_txv", 32'(tx_valid), 1);
        wait_idle("t4");

        // Timeout: req0 sends a non-last byte then goes quiet; req1 waits.
        send(0, 8'h55, 1'b0); send(1, 8'h66, 1'b1);
        own_q.push_back(0); own_q.push_back(1);
        wait_txv("t5_b0");
`ifdef UART_ARB_TIMEOUT_EN
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!timeout_err && n < 200);
        chk("t5_timeout_latency", 32'(n), 28);
        chk("t5_timeout_grant", 32'(grant), 0);
        chk("t5_timeout_busy", 32'(busy), 0);
        void'(own_q.pop_front());
        @(negedge clk);
        chk("t5_timeout_pulse_end", 32'(timeout_err), 0);
        chk("t5_next_grant", 32'(grant), 32'h2);
        wait_idle("t5");
`else
        for (int k = 0; k < 20; k++) begin
            repeat (5) @(negedge clk);
            chk("t5_grant_kept", 32'(grant), 32'h1);
            chk("t5_no_timeout", 32'(timeout_err), 0);
        end
        do_reset();
`endif

        // Reset during DRAIN, then a tie between req0 and req1.
        send(2, 8'h81, 1'b0); send(2, 8'h82, 1'b0); send(2, 8'h83, 1'b1);
        own_q.push_back(2);
        wait_txv("t6_b0");
        chk("t6_busy_before", 32'(busy), 1);
        do_reset();
        @(negedge clk);
        send(0, 8'h91, 1'b1); send(1, 8'h92, 1'b1);
        own_q.push_back(0); own_q.push_back(1);
        wait_txv("t6_tie");
        chk("t6_tie_grant", 32'(grant), 32'h1);
        wait_idle("t6");

        chk("end_scoreboard", 32'(exp_left()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
